// File: rtl/time_keeper_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_keeper_ctrl_if
//   Bundles the button pulses going into the time-of-day controller and the
//   time/mode/blink signals coming out of it.
//
//   Signals:
//     modeBtn     button pulse, one cycle, advances the set-mode state
//     incBtn      button pulse, one cycle, increments the selected field
//     hours       0..23
//     minutes     0..59
//     seconds     0..59
//     secondTick  one-cycle pulse on every seconds advance
//     mode        0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//     blink       field blink for the set modes, 1 s period, 50 % duty
//
//   Modports:
//     master  button side (drives the pulses, observes the time)
//     slave   controller side
// ---------------------------------------------------------------------------
interface time_keeper_ctrl_if;
  logic       modeBtn;
  logic       incBtn;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       secondTick;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output modeBtn, incBtn,
    input  hours, minutes, seconds, secondTick, mode, blink
  );

  modport slave (
    input  modeBtn, incBtn,
    output hours, minutes, seconds, secondTick, mode, blink
  );
endinterface

// File: rtl/time_keeper_ctrl.sv
// ---------------------------------------------------------------------------
// time_keeper_ctrl
//   Time-of-day controller for the analog clock. Divides cmosClock down to a
//   one-second tick, sequences seconds/minutes/hours and owns the user
//   set-mode state machine (run / set hours / set minutes).
//
//   Ports:
//     cmosClock  system clock, all state on the rising edge
//     reset      asynchronous, active-high
//     bus        time_keeper_ctrl_if.slave: button pulses in, time,
//                secondTick, mode and blink out (all registered)
//
//   Parameters:
//     TICKS_PER_SEC  cmosClock cycles per second (even, >= 2)
//     CNT_W          prescaler width, derived
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | time advances once per second, incBtn ignored
//   ST_SET_HOUR | time frozen, incBtn steps hours 0..23
//   ST_SET_MIN  | time frozen, incBtn steps minutes 0..59 (no carry)
// ---------------------------------------------------------------------------
module time_keeper_ctrl #(
  parameter  int unsigned TICKS_PER_SEC = 100000000,
  localparam int unsigned CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic               cmosClock,
  input  logic               reset,
  time_keeper_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] PRE_HALF = CNT_W'(TICKS_PER_SEC / 2);

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [4:0]       hours_q,     hours_d;
  logic [5:0]       minutes_q,   minutes_d;
  logic [5:0]       seconds_q,   seconds_d;
  logic             tick_q,      tick_d;
  logic             blink_q,     blink_d;

  logic             wrap;

  assign wrap = (prescaler_q == PRE_LAST);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      prescaler_q <= '0;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (bus.modeBtn) state_d = ST_SET_HOUR;
      ST_SET_HOUR: if (bus.modeBtn) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (bus.modeBtn) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    prescaler_d = wrap ? '0 : prescaler_q + CNT_W'(1);
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    tick_d      = 1'b0;

    if (bus.modeBtn) begin
      // A mode change always wins over a simultaneous tick or increment.
      // Entering SET_HOUR restarts the second so blink starts low; leaving
      // SET_MIN restarts it so the first tick is a full second away.
      if (state_q == ST_RUN) begin
        seconds_d   = '0;
        prescaler_d = '0;
      end else if (state_q == ST_SET_MIN) begin
        prescaler_d = '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (wrap) begin
            tick_d = 1'b1;
            if (seconds_q == 6'd59) begin
              seconds_d = '0;
              if (minutes_q == 6'd59) begin
                minutes_d = '0;
                hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
              end else begin
                minutes_d = minutes_q + 6'd1;
              end
            end else begin
              seconds_d = seconds_q + 6'd1;
            end
          end
        end
        ST_SET_HOUR: begin
          if (bus.incBtn) begin
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
          end
        end
        ST_SET_MIN: begin
          if (bus.incBtn) begin
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          end
        end
        default: ;
      endcase
    end

    // Blink follows the prescaler value that will be held next cycle, so the
    // high half lines up exactly with the second boundary.
    blink_d = (state_d != ST_RUN) && (prescaler_d >= PRE_HALF);
  end

  assign bus.hours      = hours_q;
  assign bus.minutes    = minutes_q;
  assign bus.seconds    = seconds_q;
  assign bus.secondTick = tick_q;
  assign bus.mode       = state_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
module tb_time_keeper_ctrl;

  localparam int unsigned TPS = 4;

  logic cmosClock = 1'b0;
  logic reset     = 1'b1;
  int   cyc;
  int   checks    = 0;
  int   failures  = 0;

  time_keeper_ctrl_if tk_if ();

  time_keeper_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .cmosClock (cmosClock),
    .reset     (reset),
    .bus       (tk_if)
  );

  always #5 cmosClock = ~cmosClock;

  // Edge counter: value at a falling edge = rising edges since reset release.
  always @(posedge cmosClock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          at;
    string       name;
    logic        tick;
    logic [1:0]  mode;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic        blink;
    bit          chk_blink;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // b < 0 means blink is not checked for this entry.
  task automatic push(input int at, input string nm, input logic tk, input int md,
                      input int h, input int m, input int s, input int b);
    exp_t e;
    e.at = at; e.name = nm; e.tick = tk; e.mode = 2'(md);
    e.h = 5'(h); e.m = 6'(m); e.s = 6'(s);
    e.blink = (b > 0); e.chk_blink = (b >= 0);
    sb.push_back(e);
  endtask

  // Monitor: compares whenever a scheduled expectation falls due; any other
  // cycle must not show a secondTick.
  always @(negedge cmosClock) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        chk({"missed_", sb[0].name}, 32'(sb[0].at), 32'(cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name,
            {12'd0, tk_if.secondTick, tk_if.mode, tk_if.hours, tk_if.minutes, tk_if.seconds},
            {12'd0, e.tick, e.mode, e.h, e.m, e.s});
        if (e.chk_blink) chk({e.name, "_blink"}, 32'(tk_if.blink), 32'(e.blink));
      end else begin
        chk("unexpected_tick", 32'(tk_if.secondTick), 32'd0);
      end
    end
  end

  task automatic press(input logic mb, input logic ib);
    tk_if.modeBtn = mb;
    tk_if.incBtn  = ib;
    @(negedge cmosClock);
    tk_if.modeBtn = 1'b0;
    tk_if.incBtn  = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge cmosClock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int n;
    tk_if.modeBtn = 1'b0;
    tk_if.incBtn  = 1'b0;

    repeat (3) @(negedge cmosClock);
    chk("reset_time", {15'd0, tk_if.hours, tk_if.minutes, tk_if.seconds}, 32'd0);
    chk("reset_mode", 32'(tk_if.mode), 32'd0);
    chk("reset_tick_blink", {30'd0, tk_if.secondTick, tk_if.blink}, 32'd0);
    reset = 1'b0;

    // Free run after release: ticks on edges 4, 8, 12, ... up to 00:00:37.
    push(4,  "tick1",      1, 0, 0, 0, 1, 0);
    push(5,  "post_tick1", 0, 0, 0, 0, 1, 0);
    push(8,  "tick2",      1, 0, 0, 0, 2, 0);
    push(12, "tick3",      1, 0, 0, 0, 3, 0);
    for (int k = 1; k <= 34; k++) push(12 + 4 * k, "run_tick", 1, 0, 0, 0, 3 + k, 0);
    wait_to(149);

    // RUN -> SET_HOUR at seconds 37, mid-second.
    push(150, "set_hour_entry", 0, 1, 0, 0, 0, 0);
    push(151, "blink_lo",       0, 1, 0, 0, 0, 0);
    push(152, "blink_hi",       0, 1, 0, 0, 0, 1);
    push(153, "blink_hi2",      0, 1, 0, 0, 0, 1);
    push(154, "blink_wrap",     0, 1, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    wait_to(154);

    for (int i = 1; i <= 25; i++) begin
      push(cyc + 1, "inc_hour", 0, 1, i % 24, 0, 0, -1);
      press(1'b0, 1'b1);
      @(negedge cmosClock);
    end
    push(cyc + 1, "to_set_min", 0, 2, 1, 0, 0, -1);
    press(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      push(cyc + 1, "inc_min", 0, 2, 1, i % 60, 0, -1);
      press(1'b0, 1'b1);
      @(negedge cmosClock);
    end

    // SET_MIN -> RUN: first tick four edges later; then modeBtn on a wrap edge.
    e = cyc + 1;
    push(e, "to_run", 0, 0, 1, 0, 0, 0);
    press(1'b1, 1'b0);
    push(e + 3,  "pre_first_tick", 0, 0, 1, 0, 0, 0);
    push(e + 4,  "first_tick",     1, 0, 1, 0, 1, 0);
    push(e + 8,  "second_tick",    1, 0, 1, 0, 2, 0);
    push(e + 12, "mode_on_wrap",   0, 1, 1, 0, 0, 0);
    push(e + 13, "no_late_tick",   0, 1, 1, 0, 0, -1);
    wait_to(e + 11);
    press(1'b1, 1'b0);
    @(negedge cmosClock);

    // Up to hours 5, then modeBtn+incBtn together.
    for (int i = 1; i <= 4; i++) begin
      push(cyc + 1, "inc_to_5", 0, 1, 1 + i, 0, 0, -1);
      press(1'b0, 1'b1);
      @(negedge cmosClock);
    end
    push(cyc + 1, "mode_and_inc", 0, 2, 5, 0, 0, -1);
    press(1'b1, 1'b1);
    @(negedge cmosClock);
    push(cyc, "mode_and_inc_hold", 0, 2, 5, 0, 0, -1);
    @(negedge cmosClock);

    for (int i = 1; i <= 59; i++) begin
      push(cyc + 1, "inc_min_59", 0, 2, 5, i, 0, -1);
      press(1'b0, 1'b1);
      @(negedge cmosClock);
    end
    push(cyc + 1, "run_5_59", 0, 0, 5, 59, 0, 0);
    press(1'b1, 1'b0);
    push(cyc + 1, "set_hour_again", 0, 1, 5, 59, 0, -1);
    press(1'b1, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      push(cyc + 1, "inc_hour_23", 0, 1, 5 + i, 59, 0, -1);
      press(1'b0, 1'b1);
      @(negedge cmosClock);
    end
    push(cyc + 1, "set_min_23", 0, 2, 23, 59, 0, -1);
    press(1'b1, 1'b0);

    // Run from 23:59:00 through midnight.
    e = cyc + 1;
    push(e, "run_23_59", 0, 0, 23, 59, 0, 0);
    press(1'b1, 1'b0);
    for (int k = 1; k <= 59; k++) push(e + 4 * k, "tick_to_59", 1, 0, 23, 59, k, 0);
    push(e + 239, "hold_23_59_59", 0, 0, 23, 59, 59, 0);
    push(e + 240, "midnight",      1, 0, 0, 0, 0, 0);
    push(e + 241, "after_midnight", 0, 0, 0, 0, 0, 0);
    wait_to(e + 241);

    // Into SET_MIN, wait for blink high, then reset between edges.
    push(cyc + 1, "set_hour_last", 0, 1, 0, 0, 0, -1);
    press(1'b1, 1'b0);
    push(cyc + 1, "set_min_last", 0, 2, 0, 0, 0, -1);
    press(1'b1, 1'b0);
    n = 0;
    while (tk_if.blink !== 1'b1 && n < 6) begin
      @(negedge cmosClock);
      n++;
    end
    chk("blink_before_reset", 32'(tk_if.blink), 32'd1);
    chk("mode_before_reset", 32'(tk_if.mode), 32'd2);
    chk("queue_before_reset", 32'(sb.size()), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_time", {15'd0, tk_if.hours, tk_if.minutes, tk_if.seconds}, 32'd0);
    chk("async_rst_mode", 32'(tk_if.mode), 32'd0);
    chk("async_rst_blink", 32'(tk_if.blink), 32'd0);
    chk("async_rst_tick", 32'(tk_if.secondTick), 32'd0);
    repeat (2) @(negedge cmosClock);
    reset = 1'b0;

    push(4, "restart_tick1", 1, 0, 0, 0, 1, 0);
    push(8, "restart_tick2", 1, 0, 0, 0, 2, 0);
    wait_to(9);
    chk("queue_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_keeper_ctrl.md
Name: time_keeper_ctrl

Overview:
- Time-of-day controller for the analog clock.
- Divides cmosClock into a one-second tick and sequences the seconds, minutes and hours registers that drive the hand-position logic.
- Owns the user set-mode state machine (run / set hours / set minutes), driven by pre-debounced single-cycle button pulses.
- Sits between the button debouncers and the hand/display drivers.

Parameters:
- TICKS_PER_SEC, 100000000, cmosClock cycles per second; minimum 2, must be even.
- CNT_W, $clog2(TICKS_PER_SEC), prescaler width; derived, not overridden.

Ports:
- cmosClock  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- modeBtn  input  1  single-cycle pulse, advances the mode.
- incBtn  input  1  single-cycle pulse, increments the selected field in a set mode.
- hours  output  5  0..23.
- minutes  output  6  0..59.
- seconds  output  6  0..59.
- secondTick  output  1  one-cycle pulse when seconds advance.
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 never driven.
- blink  output  1  set-mode field blink, 50% duty, 1 s period.

Behaviour:
- Reset (async, active-high):
  - hours = minutes = seconds = 0.
  - prescaler = 0, mode = RUN, secondTick = 0, blink = 0.
  - Reset applied mid-operation aborts any mode or carry immediately.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 every cycle in all modes, then wraps to 0.
  - Event "wrap" = prescaler == TICKS_PER_SEC-1.
- RUN mode:
  - On a wrap cycle, secondTick = 1 on the following cycle, registered together with the time update.
  - Seconds increment in that same update.
  - Carry chain, all in one cycle:
    - seconds 59 -> 0 with minutes +1.
    - minutes 59 -> 0 with hours +1.
    - hours 23 -> 0.
    - 23:59:59 -> 00:00:00 in a single update.
  - incBtn ignored.
- FSM transitions on modeBtn:
  - RUN -> SET_HOUR: seconds cleared to 0 and prescaler cleared to 0 on the same edge.
  - SET_HOUR -> SET_MIN: no side effects.
  - SET_MIN -> RUN: prescaler cleared to 0, so the first tick comes exactly TICKS_PER_SEC cycles after the transition edge.
- Set modes:
  - No time advance; secondTick held 0.
  - incBtn in SET_HOUR: hours +1, 23 -> 0.
  - incBtn in SET_MIN: minutes +1, 59 -> 0, no carry into hours.
  - Each incBtn pulse gives exactly one increment, applied on the next edge.
- Simultaneous events:
  - modeBtn and incBtn in the same cycle: mode transition taken, incBtn discarded.
  - modeBtn (RUN -> SET_HOUR) on a wrap cycle: the transition wins; no tick, no seconds increment, seconds = 0.
- blink:
  - 0 in RUN.
  - In set modes, registered value of (prescaler >= TICKS_PER_SEC/2); low for the first half-second after entering SET_HOUR.
- Latency:
  - All outputs registered; button effect visible one cycle after the pulse.
- Widths:
  - Increments use exact-width compare against the terminal value before adding, so there is no overflow path.
  - Out-of-range values are unreachable.

Test Plan (TICKS_PER_SEC=4 unless noted):
- Release reset, run 12 cycles -> secondTick pulses on cycles 4, 8 and 12 after reset release; seconds = 3; minutes = hours = 0; mode = 0.
- Force time to 23:59:59 via set-mode sequence plus ticks, then one more tick -> 00:00:00 on the same cycle secondTick = 1; no intermediate values.
- modeBtn from RUN at seconds = 37 -> mode = 1, seconds = 0. Then 25 incBtn pulses -> hours = 1 (24 wraps to 0, plus 1). modeBtn -> mode = 2. 60 incBtn pulses -> minutes back to start, hours unchanged. modeBtn -> mode = 0; first secondTick exactly 4 cycles later.
- modeBtn and incBtn asserted in the same cycle in SET_HOUR at hours = 5 -> mode = 2, hours stays 5.
- modeBtn on a prescaler wrap cycle in RUN -> no secondTick, mode = 1, seconds = 0.
- Assert reset asynchronously (between edges) while in SET_MIN with blink = 1 -> all outputs 0 and mode = 0 immediately, without waiting for a clock edge; counting restarts cleanly after release.
